acc_cpu_param: RTL and testbench
================================

# acc_cpu_param

Parametrised, multi-cycle accumulator processor, the next generation of the lab single-accumulator CPU. It fetches single-word instructions from an external memory through a ready-based handshake with wait states. Every memory-referencing opcode supports direct and indirect addressing. It adds AND, HLT/resume, a signed jump test and a persistent carry flag. It sits between the lab memory model (or block RAM with a ready strobe) and the board display logic that shows `ac`/`pc`.

## Interface
- `ADDR_W`, 12, address width; data/instruction width is fixed at `DATA_W = ADDR_W+4` (localparam). Instruction word: [DATA_W-1:DATA_W-3] opcode, [DATA_W-4] AM (1 = indirect), [ADDR_W-1:0] address field.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_addr`  out  ADDR_W  memory address; valid whenever `mem_rd` or `mem_wr` is high.
- `mem_rd`  out  1  read request.
- `mem_wr`  out  1  write request.
- `mem_wdata`  out  DATA_W  write data (= AC while `mem_wr`).
- `mem_rdata`  in  DATA_W  read data; sampled on the edge where `mem_ready`=1.
- `mem_ready`  in  1  completes the pending transfer this cycle.
- `run`  in  1  resumes execution from the halted state.
- `ac`  out  DATA_W  accumulator.
- `pc`  out  ADDR_W  program counter.
- `carry`  out  1  carry flag.
- `halted`  out  1  high while in HALT.

## Operation
- States: BOOT, FETCH, DECODE, INDIR, EXEC_RD, EXEC_WR, HALT. Reset state is BOOT.
- `mem_rd`, `mem_wr` and `mem_addr` are decoded combinationally from the state.
  - `mem_rd`=1 in FETCH/INDIR/EXEC_RD.
  - `mem_wr`=1 in EXEC_WR.
- BOOT → FETCH unconditionally.
- FETCH: `mem_addr`=PC. On ready: IR←rdata, PC←PC+1 (wraps modulo 2^ADDR_W), → DECODE.
- DECODE: EA←IR address field.
  - 000 NOT: AC←~AC. → FETCH.
  - 011 INC: {C,AC}←AC+1. → FETCH.
  - 010 JPA: taken iff AC signed >0 (MSB=0 and AC≠0). Not taken → FETCH. Taken and AM=0: PC←EA, → FETCH. Taken and AM=1 → INDIR.
  - 111 HLT: → HALT.
  - 001 ADC, 101 LDA, 110 AND, 100 STA: AM=1 → INDIR. AM=0 → EXEC_RD, or EXEC_WR for STA.
- INDIR: `mem_addr`=EA. On ready: EA←rdata[ADDR_W-1:0] (upper bits ignored). Then JPA: PC←new EA, → FETCH. Others → EXEC_RD, or EXEC_WR for STA.
- EXEC_RD: `mem_addr`=EA. On ready:
  - ADC: {C,AC}←AC+rdata+C, full DATA_W+1-bit sum.
  - LDA: AC←rdata.
  - AND: AC←AC&rdata.
  - Then → FETCH.
- EXEC_WR: `mem_addr`=EA, `mem_wdata`=AC. On ready → FETCH. AC and C are unchanged by STA.
- Only ADC and INC write C. Every other opcode leaves it unchanged.
- HALT: `halted`=1, no memory requests. `run`=1 → FETCH at current PC; `run` is ignored outside HALT.

## Timing
- `rst` asserted, at any time including mid-transfer: state BOOT, and `mem_rd`, `mem_wr`, `halted` go to 0 immediately (asynchronously). AC=0, C=0, IR=0, EA=0, PC=RESET_PC, `mem_addr`=0, `mem_wdata`=0.
- First FETCH request appears in the first cycle after `rst` deasserts plus one BOOT cycle.
- Handshake: the request and `mem_addr`/`mem_wdata` are held constant while `mem_ready`=0. No register changes while waiting. A transfer completes on the edge where the state requests and `mem_ready`=1. `mem_ready` is ignored when no request is active.
- With `mem_ready` tied high (clocks per instruction):
  - NOT/INC/HLT: 2.
  - JPA: 2 (direct or not taken), 3 (taken indirect).
  - ADC/LDA/AND/STA: 3 direct, 4 indirect.
- Each wait cycle adds one clock.
- Back-to-back transfers are permitted: the request stays high across a state change, with a new address.
- `mem_wr` is high for exactly the EXEC_WR state cycles; it is never simultaneous with `mem_rd`.
- `halted` rises on the edge leaving DECODE of HLT. It falls on the edge after `run` is sampled high.

## Test plan
ADDR_W=12 throughout. Memory model returns data on `mem_ready`, with variable wait counts.

- Arithmetic: M[0]=0xA100 (LDA 0x100), M[0x100]=0x7FFF, M[1]=0x2101 (ADC 0x101), M[0x101]=0x8001, M[2]=0x6000 (INC) → after ADC: AC=0x0000, C=1; after INC: AC=0x0001, C=0; `pc`=3.
- Indirect store: AC=0x1234, instruction 0x9200 (STA @0x200), M[0x200]=0xF300 → one write with `mem_addr`=0x300, data 0x1234; AC stays 0x1234; 4 clocks with zero wait.
- Jump: AC=0x0005 with 0x4040 → `pc`=0x040. AC=0x8000 or 0x0000 → `pc` increments only. AC=1 with 0x5050, M[0x050]=0x0ABC → `pc`=0xABC.
- Wait states: `mem_ready` low for 3 cycles in FETCH → `mem_rd` and `mem_addr` stable for 4 cycles; `pc` changes only on the 4th edge.
- Halt/resume: 0xE000 at PC 5 → `halted`=1, no requests for 10 cycles, `pc`=6. Pulse `run` → FETCH from 6, `halted`=0.
- Reset mid-write: assert `rst` while `mem_wr`=1 and `mem_ready`=0 → `mem_wr`=0 immediately, all outputs at reset values. After release, BOOT then fetch from RESET_PC.

Source files
------------

// File: rtl/acc_cpu_param_if.sv
// Memory bus of acc_cpu_param: single outstanding transfer, completed by mem_ready.
interface acc_cpu_param_if #(
  parameter int unsigned ADDR_W = 12
);
  localparam int unsigned DATA_W = ADDR_W + 4;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/acc_cpu_param.sv
// Multi-cycle accumulator CPU: direct/indirect addressing, carry flag, halt/resume,
// instruction and data fetched over a ready-based memory bus with wait states.
module acc_cpu_param #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  acc_cpu_param_if.master     bus,
  input  logic                run_i,
  output logic [ADDR_W+3:0]   ac_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                carry_o,
  output logic                halted_o
);

  localparam int unsigned DATA_W = ADDR_W + 4;
  localparam int unsigned SUM_W  = DATA_W + 1;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_JPA = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_INDIR   = 3'd3,
    S_EXEC_RD = 3'd4,
    S_EXEC_WR = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              c_q, c_d;

  logic [2:0]        opcode;
  logic              am;
  logic [ADDR_W-1:0] addr_field;
  logic              jpa_taken;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_rd_c;
  logic              mem_wr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign opcode     = ir_q[DATA_W-1 -: 3];
  assign am         = ir_q[DATA_W-4];
  assign addr_field = ir_q[ADDR_W-1:0];
  // Signed greater-than-zero: sign bit clear and not all zero.
  assign jpa_taken  = ~ac_q[DATA_W-1] & (|ac_q);

  // Bus request decoded from the state alone, so it holds steady across wait cycles.
  always_comb begin
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state_q)
      S_FETCH: begin
        mem_rd_c   = 1'b1;
        mem_addr_c = pc_q;
      end
      S_INDIR, S_EXEC_RD: begin
        mem_rd_c   = 1'b1;
        mem_addr_c = ea_q;
      end
      S_EXEC_WR: begin
        mem_wr_c    = 1'b1;
        mem_addr_c  = ea_q;
        mem_wdata_c = ac_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_rd    = mem_rd_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      ac_q    <= '0;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
      ea_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      ea_q    <= ea_d;
      c_q     <= c_d;
    end
  end

  // Next-state and datapath updates; memory states advance only on mem_ready.
  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    ea_d    = ea_q;
    c_d     = c_q;

    case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ea_d = addr_field;
        case (opcode)
          OP_NOT: begin
            ac_d    = ~ac_q;
            state_d = S_FETCH;
          end
          OP_INC: begin
            {c_d, ac_d} = SUM_W'(ac_q) + SUM_W'(1'b1);
            state_d     = S_FETCH;
          end
          OP_JPA: begin
            state_d = S_FETCH;
            if (jpa_taken) begin
              if (am) state_d = S_INDIR;
              else    pc_d    = addr_field;
            end
          end
          OP_HLT: state_d = S_HALT;
          default: begin
            if (am)                  state_d = S_INDIR;
            else if (opcode == OP_STA) state_d = S_EXEC_WR;
            else                     state_d = S_EXEC_RD;
          end
        endcase
      end

      S_INDIR: begin
        if (bus.mem_ready) begin
          ea_d = bus.mem_rdata[ADDR_W-1:0];
          if (opcode == OP_JPA) begin
            pc_d    = bus.mem_rdata[ADDR_W-1:0];
            state_d = S_FETCH;
          end else if (opcode == OP_STA) begin
            state_d = S_EXEC_WR;
          end else begin
            state_d = S_EXEC_RD;
          end
        end
      end

      S_EXEC_RD: begin
        if (bus.mem_ready) begin
          case (opcode)
            OP_ADC:  {c_d, ac_d} = SUM_W'(ac_q) + SUM_W'(bus.mem_rdata) + SUM_W'(c_q);
            OP_LDA:  ac_d = bus.mem_rdata;
            OP_AND:  ac_d = ac_q & bus.mem_rdata;
            default: ;
          endcase
          state_d = S_FETCH;
        end
      end

      S_EXEC_WR: begin
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_HALT: begin
        if (run_i) state_d = S_FETCH;
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign ac_o     = ac_q;
  assign pc_o     = pc_q;
  assign carry_o  = c_q;
  assign halted_o = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: memory with wait states, instruction-level reference model
// that predicts every bus cycle, and directed checks taken from hand-run programs.
module tb_acc_cpu_param;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;

  typedef struct packed {
    logic [1:0]    k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } xf_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_i = 1'b0;
  logic [DW-1:0] ac_o;
  logic [AW-1:0] pc_o;
  logic          carry_o;
  logic          halted_o;

  acc_cpu_param_if #(.ADDR_W(AW)) bus ();

  acc_cpu_param #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .run_i    (run_i),
    .ac_o     (ac_o),
    .pc_o     (pc_o),
    .carry_o  (carry_o),
    .halted_o (halted_o)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            bnd_cnt = 0;
  int            bnd_cyc = 0;
  logic [AW-1:0] last_bnd_pc = '0;
  bit            wait_mode = 1'b0;

  logic [DW-1:0] mem   [4096];
  logic [DW-1:0] m_mem [4096];
  logic [DW-1:0] m_ac;
  logic [AW-1:0] m_pc;
  logic          m_c;
  bit            m_halted;
  bit            run_seen;
  xf_t           exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] img(input int a);
    case (a)
      'h000: return 16'hA100;  'h001: return 16'h2101;  'h002: return 16'h6000;
      'h003: return 16'hA102;  'h004: return 16'h9200;  'h005: return 16'hE000;
      'h006: return 16'hA103;  'h007: return 16'h4040;
      'h040: return 16'hA104;  'h041: return 16'h4060;  'h042: return 16'hA105;
      'h043: return 16'h4060;  'h044: return 16'h6000;  'h045: return 16'h5050;
      'h050: return 16'h0ABC;
      'h100: return 16'h7FFF;  'h101: return 16'h8001;  'h102: return 16'h1234;
      'h103: return 16'h0005;  'h104: return 16'h8000;  'h105: return 16'h0000;
      'h106: return 16'hF0F0;  'h107: return 16'h3C3C;  'h108: return 16'h0110;
      'h109: return 16'h0001;  'h10A: return 16'hF111;  'h10B: return 16'h0112;
      'h110: return 16'h4000;  'h111: return 16'hFFFF;  'h112: return 16'hFFFF;
      'h115: return 16'hBEEF;
      'h200: return 16'hF300;
      'hABC: return 16'hA106;  'hABD: return 16'hC107;  'hABE: return 16'h0000;
      'hABF: return 16'h3108;  'hAC0: return 16'h2109;  'hAC1: return 16'hB10A;
      'hAC2: return 16'h6000;  'hAC3: return 16'hD10B;  'hAC4: return 16'h8115;
      'hAC5: return 16'h6000;  'hAC6: return 16'h8114;  'hAC7: return 16'hE000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic xf_t mk(input logic [1:0] k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    xf_t x;
    x.k = k; x.a = a; x.d = d;
    return x;
  endfunction

  // One instruction at ISA level: update architectural state, queue the bus cycles it costs.
  task automatic model_step();
    logic [DW-1:0] w, d;
    logic [AW-1:0] ea;
    logic [2:0]    op;
    w  = m_mem[m_pc];
    op = w[15:13];
    ea = w[11:0];
    exp_q.push_back(mk(K_RD, m_pc, '0));
    exp_q.push_back(mk(K_IDLE, '0, '0));
    m_pc = m_pc + 12'd1;
    case (op)
      3'b000: m_ac = ~m_ac;
      3'b011: {m_c, m_ac} = 17'(m_ac) + 17'd1;
      3'b111: m_halted = 1'b1;
      3'b010: begin
        if (!m_ac[15] && m_ac != 16'h0) begin
          if (w[12]) begin
            exp_q.push_back(mk(K_RD, ea, '0));
            m_pc = m_mem[ea][11:0];
          end else begin
            m_pc = ea;
          end
        end
      end
      default: begin
        if (w[12]) begin
          exp_q.push_back(mk(K_RD, ea, '0));
          ea = m_mem[ea][11:0];
        end
        if (op == 3'b100) begin
          exp_q.push_back(mk(K_WR, ea, m_ac));
          m_mem[ea] = m_ac;
        end else begin
          exp_q.push_back(mk(K_RD, ea, '0));
          d = m_mem[ea];
          if (op == 3'b001)      {m_c, m_ac} = 17'(m_ac) + 17'(d) + 17'(m_c);
          else if (op == 3'b101) m_ac = d;
          else                   m_ac = m_ac & d;
        end
      end
    endcase
  endtask

  // Memory: starts each transfer after the edge, inserts wait cycles, commits writes on completion.
  initial begin
    bit            comp, started, c_wr;
    int            wl, xcnt;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    for (int i = 0; i < 4096; i++) mem[i] = img(i);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    started = 1'b0; wl = 0; xcnt = 0;
    forever begin
      @(negedge clk);
      comp   = (bus.mem_rd | bus.mem_wr) & bus.mem_ready;
      c_wr   = bus.mem_wr;
      c_addr = bus.mem_addr;
      c_data = bus.mem_wdata;
      @(posedge clk);
      #1;
      if (rst) started = 1'b0;
      else if (comp) begin
        if (c_wr) mem[c_addr] = c_data;
        started = 1'b0;
      end
      if (!rst && (bus.mem_rd || bus.mem_wr)) begin
        if (!started) begin
          started = 1'b1;
          xcnt++;
          if (bus.mem_rd && bus.mem_addr == 12'hAC5)      wl = 3;
          else if (bus.mem_wr && bus.mem_addr == 12'h114) wl = 6;
          else if (wait_mode)                             wl = xcnt % 3;
          else                                            wl = 0;
        end
        if (wl == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 16'hDEAD;
          wl--;
        end
      end else begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5A5A;
      end
    end
  end

  // Compare process: every cycle the bus and halt flag must match the model's queued cycles.
  initial begin
    xf_t h;
    bit  req;
    for (int i = 0; i < 4096; i++) m_mem[i] = img(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("reset_vals", {bus.mem_rd, bus.mem_wr, halted_o, bus.mem_addr, bus.mem_wdata, ac_o, pc_o, carry_o},
            {3'b000, 12'h000, 16'h0000, 16'h0000, 12'h000, 1'b0});
        m_ac = '0; m_pc = 12'h000; m_c = 1'b0; m_halted = 1'b0; run_seen = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(K_IDLE, '0, '0));
      end else begin
        req = bus.mem_rd | bus.mem_wr;
        if (exp_q.size() == 0) begin
          if (req) begin
            if (m_halted) chk("halt_exit_run", run_seen, 1'b1);
            m_halted = 1'b0; run_seen = 1'b0;
            chk("arch_state", {ac_o, pc_o, carry_o}, {m_ac, m_pc, m_c});
            bnd_cnt++; last_bnd_pc = m_pc; bnd_cyc = cyc;
            model_step();
          end else begin
            chk("halt_hold", halted_o & m_halted, 1'b1);
            if (run_i && m_halted) run_seen = 1'b1;
          end
        end
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          if (h.k == K_IDLE) begin
            chk("bus_idle", {bus.mem_rd, bus.mem_wr, halted_o}, 3'b000);
            void'(exp_q.pop_front());
          end else if (h.k == K_RD) begin
            chk("bus_rd", {halted_o, bus.mem_rd, bus.mem_wr, bus.mem_addr}, {3'b010, h.a});
            if (bus.mem_ready) void'(exp_q.pop_front());
          end else begin
            chk("bus_wr", {halted_o, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, {3'b001, h.a, h.d});
            if (bus.mem_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_bnd(input logic [AW-1:0] want, input int budget, input string nm);
    int start;
    bit hit;
    start = bnd_cnt;
    hit   = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (bnd_cnt != start && last_bnd_pc == want) hit = 1'b1;
    end
    chk(nm, hit, 1'b1);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    int  t4, reqs;
    bit  all_halt, stable, found;
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {bus.mem_rd, bus.mem_wr, halted_o, pc_o, ac_o}, {3'b000, 12'h000, 16'h0000});
    rst = 1'b0;

    wait_bnd(12'h002, 50, "reach_pc2");
    chk("adc_ac_c", {ac_o, carry_o}, {16'h0000, 1'b1});
    wait_bnd(12'h003, 50, "reach_pc3");
    chk("inc_ac_c_pc", {ac_o, carry_o, pc_o}, {16'h0001, 1'b0, 12'h003});
    wait_bnd(12'h004, 50, "reach_pc4");
    t4 = bnd_cyc;
    chk("lda_ac", ac_o, 16'h1234);
    wait_bnd(12'h005, 50, "reach_pc5");
    chk("sta_ind_cycles", 64'(bnd_cyc - t4), 64'd4);
    chk("sta_ind_mem", mem[12'h300], 16'h1234);
    chk("sta_ac_kept", ac_o, 16'h1234);

    step();
    all_halt = 1'b1; reqs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      all_halt &= halted_o;
      if (bus.mem_rd || bus.mem_wr) reqs++;
    end
    chk("halted_10", all_halt, 1'b1);
    chk("halt_no_req", 64'(reqs), 64'd0);
    chk("halt_pc", pc_o, 12'h006);
    @(posedge clk); #1; run_i = 1'b1;
    @(posedge clk); #1; run_i = 1'b0;
    wait_bnd(12'h006, 10, "resume_pc6");
    chk("resume_halted", halted_o, 1'b0);

    wait_bnd(12'h040, 50, "jpa_direct");
    wait_bnd(12'h042, 50, "jpa_neg_skip");
    chk("ac_8000", ac_o, 16'h8000);
    wait_bnd(12'h044, 50, "jpa_zero_skip");
    chk("ac_0000", ac_o, 16'h0000);
    wait_bnd(12'hABC, 50, "jpa_indirect");
    wait_mode = 1'b1;

    wait_bnd(12'hAC0, 200, "reach_ac0");
    chk("and_not_adcind", {ac_o, carry_o}, {16'h0FCF, 1'b1});
    wait_bnd(12'hAC1, 100, "reach_ac1");
    chk("adc_cin", {ac_o, carry_o}, {16'h0FD1, 1'b0});
    wait_bnd(12'hAC4, 200, "reach_ac4");
    chk("lda_ind_inc_and", {ac_o, carry_o}, {16'h0000, 1'b1});

    wait_bnd(12'hAC5, 100, "reach_ac5");
    chk("sta_direct_mem", mem[12'h115], 16'h0000);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      stable &= bus.mem_rd && (bus.mem_addr == 12'hAC5) && (pc_o == 12'hAC5);
    end
    chk("wait_stable", stable, 1'b1);
    step();
    chk("wait_pc_after", pc_o, 12'hAC6);

    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (bus.mem_wr && bus.mem_addr == 12'h114) found = 1'b1;
    end
    chk("find_write", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write", {bus.mem_rd, bus.mem_wr, halted_o, bus.mem_addr, bus.mem_wdata, ac_o, pc_o, carry_o},
        {3'b000, 12'h000, 16'h0000, 16'h0000, 12'h000, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("boot_idle", {bus.mem_rd, bus.mem_wr}, 2'b00);
    step();
    chk("boot_fetch", {bus.mem_rd, bus.mem_addr}, {1'b1, 12'h000});
    wait_bnd(12'h005, 200, "rerun_pc5");
    repeat (4) step();
    chk("rerun_halted", {halted_o, pc_o}, {1'b1, 12'h006});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
